// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared constants for the core-side RAM ports, the 8-bit
//                data RAM arbiter and its benches: data/address widths,
//                default latencies and the port FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

   // RAM data and address widths (one byte lane per core)
   localparam int DATA_W = 8;
   localparam int ADDR_W = 8;

   // Default latencies, shared with the arbiter
   localparam int RD_LAT_DEF  = 3;
   localparam int WR_HOLD_DEF = 2;

   // Port FSM state encoding
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_REQ  = 3'd1;
   localparam logic [2:0] ST_XFER = 3'd2;
   localparam logic [2:0] ST_DONE = 3'd3;
   localparam logic [2:0] ST_REL  = 3'd4;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/core_mem_port.sv
`default_nettype none
// ============================================================================
//  Module      : core_mem_port
//  Description : Core-side initiator for the shared 8-bit data RAM arbiter.
//                Accepts one load/store, raises this core's rden/wren lane,
//                waits for acq, counts out the RAM latency, returns a
//                one-cycle response and then forces a release cycle so the
//                round-robin arbiter can rotate.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_mem_port
   import mem_pkg::*;
#(
   parameter int RD_LAT  = RD_LAT_DEF,
   parameter int WR_HOLD = WR_HOLD_DEF,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              mem_rden,
   output logic              mem_wren,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic              mem_acq,
   input  logic [DATA_W-1:0] mem_dq
);

   // Terminal counts for the XFER and REQ phases
   localparam logic [CNT_W-1:0] c_RD_LAST = CNT_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0] c_WR_LAST = CNT_W'(WR_HOLD - 1);
   localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT - 1);

   logic [2:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_req_ready;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;
   logic              r_rden;
   logic              r_wren;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_din;

   logic [CNT_W-1:0]  w_cnt_inc;
   logic              w_rd_done;
   logic              w_wr_done;
   logic              w_timeout;

   // Saturating increment and phase-end decodes; the active lane tells
   // whether the held transaction is a read or a write
   assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
   assign w_rd_done = r_rden && (r_cnt == c_RD_LAST);
   assign w_wr_done = r_wren && (r_cnt == c_WR_LAST);
   assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_TO_LAST);

   // Transaction FSM with its single shared counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_rden      <= 1'b0;
         r_wren      <= 1'b0;
         r_addr      <= '0;
         r_din       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (req_valid && r_req_ready) begin
                  r_req_ready <= 1'b0;
                  r_addr      <= req_addr;
                  r_din       <= req_wdata;
                  r_rden      <= ~req_we;
                  r_wren      <= req_we;
                  r_state     <= ST_REQ;
               end else begin
                  r_req_ready <= 1'b1;
               end
            end
            ST_REQ: begin
               if (mem_acq) begin
                  r_cnt   <= '0;
                  r_state <= ST_XFER;
               end else if (w_timeout) begin
                  // Give up without touching the RAM
                  r_rden      <= 1'b0;
                  r_wren      <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            ST_XFER: begin
               if (!mem_acq) begin
                  // Grant lost: keep the lane up and restart the wait
                  r_cnt   <= '0;
                  r_state <= ST_REQ;
               end else if (w_rd_done) begin
                  r_rsp_rdata <= mem_dq;
                  r_rden      <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end else if (w_wr_done) begin
                  r_wren      <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            ST_DONE: begin
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
               r_cnt       <= '0;
               r_state     <= ST_REL;
            end
            ST_REL: begin
               // Second lane-low cycle so the arbiter can rotate
               r_req_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_rden      <= 1'b0;
               r_wren      <= 1'b0;
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
               r_req_ready <= 1'b0;
               r_cnt       <= '0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign mem_rden  = r_rden;
   assign mem_wren  = r_wren;
   assign mem_addr  = r_addr;
   assign mem_din   = r_din;

endmodule : core_mem_port
`default_nettype wire

// File: tb/tb_core_mem_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_mem_port
//  Description : Self-checking bench for core_mem_port with a small arbiter
//                and RAM model; a second instance with a short timeout
//                exercises the abort path.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_core_mem_port;
   import mem_pkg::*;

   localparam int RD_LAT  = 3;
   localparam int WR_HOLD = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0, req_we = 1'b0;
   logic [7:0] req_addr = 8'h00, req_wdata = 8'h00;
   logic       req_ready, rsp_valid, rsp_err, mem_rden, mem_wren, mem_acq;
   logic [7:0] rsp_rdata, mem_addr, mem_din, mem_dq;

   logic       to_req_valid = 1'b0, to_req_we = 1'b0;
   logic [7:0] to_req_addr = 8'h00, to_req_wdata = 8'h00;
   logic       to_req_ready, to_rsp_valid, to_rsp_err, to_mem_rden, to_mem_wren;
   logic [7:0] to_rsp_rdata, to_mem_addr, to_mem_din;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   core_mem_port #(.RD_LAT(RD_LAT), .WR_HOLD(WR_HOLD), .TIMEOUT(255), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_acq(mem_acq), .mem_dq(mem_dq)
   );

   core_mem_port #(.RD_LAT(RD_LAT), .WR_HOLD(WR_HOLD), .TIMEOUT(5), .CNT_W(8)) dut_to (
      .clk(clk), .rst(rst), .req_valid(to_req_valid), .req_we(to_req_we),
      .req_addr(to_req_addr), .req_wdata(to_req_wdata), .req_ready(to_req_ready),
      .rsp_valid(to_rsp_valid), .rsp_rdata(to_rsp_rdata), .rsp_err(to_rsp_err),
      .mem_rden(to_mem_rden), .mem_wren(to_mem_wren), .mem_addr(to_mem_addr),
      .mem_din(to_mem_din), .mem_acq(1'b0), .mem_dq(8'h00)
   );

   // ---------------- arbiter + RAM model ----------------
   logic [7:0] ram [256];
   bit         ram_init  = 1'b0;
   int         hc        = 0;     // consecutive cycles of acq & rden
   int         bc        = 0;     // grant-delay counter
   int         block_req = 0;     // cycles another core holds the arbiter
   logic       r_acq_m   = 1'b0;
   logic       man_mode  = 1'b0;
   logic       man_acq   = 1'b0;

   assign mem_acq = man_mode ? man_acq : r_acq_m;
   assign mem_dq  = (hc >= RD_LAT) ? ram[mem_addr] : 8'hEE;

   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
         ram[8'h12] <= 8'hA5;
         ram_init   <= 1'b1;
      end else if (mem_wren && mem_acq) begin
         ram[mem_addr] <= mem_din;
      end
      hc <= (mem_acq && mem_rden) ? hc + 1 : 0;
      if (!(mem_rden || mem_wren)) begin
         bc      <= 0;
         r_acq_m <= 1'b0;
      end else if (bc < block_req) begin
         bc      <= bc + 1;
         r_acq_m <= 1'b0;
      end else begin
         r_acq_m <= 1'b1;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic handshake(input logic we, input logic [7:0] a, input logic [7:0] d, output bit ok);
      bit rdy;
      ok        = 1'b0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      for (int n = 0; n < 20; n++) begin
         rdy = req_ready;
         step();
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      req_valid = 1'b0;
      if (!ok) chk("handshake_bound", 0, 1);
   endtask

   task automatic do_txn(input logic we, input logic [7:0] a, input logic [7:0] d, input int blk,
                         output int lat, output int lane, output int bad,
                         output logic [7:0] rd, output logic er);
      bit ok;
      block_req = blk;
      lat  = 0;
      lane = 0;
      bad  = 0;
      rd   = 8'h00;
      er   = 1'b0;
      handshake(we, a, d, ok);
      if (ok) begin
         while (!rsp_valid && lat < 100) begin
            if (mem_rden || mem_wren) lane++;
            if (mem_rden === we || mem_wren !== we || mem_addr !== a || mem_din !== d) bad++;
            step();
            lat++;
         end
         rd = rsp_rdata;
         er = rsp_err;
         if (mem_rden || mem_wren) bad++;
         step();
         if (rsp_valid || mem_rden || mem_wren || req_ready) bad++;
         step();
         if (!req_ready) bad++;
      end
   endtask

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      int         blk;
      logic [7:0] exp_rd;
      int         exp_lat;
      int         exp_lane;
   } vec_t;

   vec_t vt [7];

   // ---------------- main sequence ----------------
   initial begin
      int         lat, lane, bad, seen;
      logic [7:0] rd;
      logic       er;
      bit         ok;

      // latency = 2 (REQ, acq arrives one cycle late) + blocked cycles + hold
      vt[0] = '{1'b0, 8'h12, 8'h00,  0, 8'hA5,  5,  5};
      vt[1] = '{1'b1, 8'h40, 8'h3C,  0, 8'hA5,  4,  4};
      vt[2] = '{1'b0, 8'h40, 8'h00,  0, 8'h3C,  5,  5};
      vt[3] = '{1'b0, 8'h80, 8'h00, 10, 8'hDA, 15, 15};
      vt[4] = '{1'b1, 8'h81, 8'h77,  3, 8'hDA,  7,  7};
      vt[5] = '{1'b0, 8'h81, 8'h00,  0, 8'h77,  5,  5};
      vt[6] = '{1'b0, 8'h03, 8'h00,  1, 8'h59,  6,  6};

      rst = 1'b1;
      repeat (3) step();
      chk("reset_outputs", int'({req_ready, rsp_valid, rsp_err, mem_rden, mem_wren,
                                 rsp_rdata, mem_addr, mem_din}), 0);
      chk("reset_outputs_to", int'({to_req_ready, to_rsp_valid, to_rsp_err, to_mem_rden,
                                    to_mem_wren, to_rsp_rdata, to_mem_addr, to_mem_din}), 0);
      rst = 1'b0;
      step();
      chk("ready_after_reset", int'(req_ready), 1);

      for (int i = 0; i < 7; i++) begin
         do_txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].blk, lat, lane, bad, rd, er);
         chk($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
         chk($sformatf("v%0d_lane_cycles", i), lane, vt[i].exp_lane);
         chk($sformatf("v%0d_lane_protocol", i), bad, 0);
         chk($sformatf("v%0d_rdata", i), int'(rd), int'(vt[i].exp_rd));
         chk($sformatf("v%0d_err", i), int'(er), 0);
      end

      // Grant loss in the second XFER cycle, then regrant
      block_req = 0;
      man_mode  = 1'b1;
      man_acq   = 1'b0;
      seen      = 0;
      handshake(1'b0, 8'h40, 8'h00, ok);
      man_acq = 1'b1;
      step(); seen += int'(rsp_valid);
      step(); seen += int'(rsp_valid);
      man_acq = 1'b0;
      step();
      chk("gl_rden_held", int'(mem_rden && mem_addr == 8'h40), 1);
      chk("gl_no_rsp", seen + int'(rsp_valid), 0);
      man_acq = 1'b1;
      lat = 3;
      while (!rsp_valid && lat < 100) begin
         step();
         lat++;
      end
      chk("gl_latency", lat, 7);
      chk("gl_rdata", int'(rsp_rdata), 8'h3C);
      man_acq = 1'b0;
      step();
      step();
      man_mode = 1'b0;

      // Reset while in XFER
      handshake(1'b0, 8'h12, 8'h00, ok);
      step(); step(); step();
      chk("rm_in_xfer", int'(mem_rden && mem_acq), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rm_outputs", int'({req_ready, rsp_valid, rsp_err, mem_rden, mem_wren,
                              rsp_rdata, mem_addr, mem_din}), 0);
      seen = 0;
      repeat (6) begin
         step();
         seen += int'(rsp_valid);
      end
      chk("rm_no_rsp", seen, 0);
      do_txn(1'b0, 8'h12, 8'h00, 0, lat, lane, bad, rd, er);
      chk("rm_after_latency", lat, 5);
      chk("rm_after_rdata", int'(rd), 8'hA5);

      // Timeout instance: acq never arrives
      to_req_valid = 1'b1;
      to_req_we    = 1'b0;
      to_req_addr  = 8'h55;
      to_req_wdata = 8'h00;
      lat = 0;
      while (!to_req_ready && lat < 20) begin
         step();
         lat++;
      end
      step();
      to_req_valid = 1'b0;
      lat  = 0;
      lane = 0;
      while (!to_rsp_valid && lat < 50) begin
         if (to_mem_rden) lane++;
         step();
         lat++;
      end
      chk("to_latency", lat, 5);
      chk("to_rden_cycles", lane, 5);
      chk("to_err_and_lane", int'({to_rsp_err, to_mem_rden, to_mem_wren}), 3'b100);
      step();
      chk("to_pulse_single", int'({to_rsp_valid, to_rsp_err}), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
      $fatal(1);
   end

endmodule : tb_core_mem_port
`default_nettype wire
